fu_mul_pipe: RTL
================

// Module: fu_mul_pipe
// PURPOSE
//  Parametrised, fully pipelined integer multiply functional unit for the core's EX stage.
//  Accepts one operation per cycle with a valid/ready handshake and carries an issue tag.
//  Supports four RISC-V style modes: low product, signed high, signed x unsigned high, unsigned high.
//  Adds output backpressure, a pipeline flush and a busy flag.
// PARAMETERS
//  WIDTH    32  operand and result width in bits (>= 4)
//  LATENCY  7   pipeline stages from accept to result (>= 2)
//  TAG_W    5   width of the issue tag carried alongside each operation
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous reset, active-low
//  in_valid   in   1         operation offered this cycle
//  in_ready   out  1         unit can accept this cycle
//  in_a       in   WIDTH     operand A (rs1)
//  in_b       in   WIDTH     operand B (rs2)
//  in_op      in   2         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  in_tag     in   TAG_W     issue tag, returned unchanged with the result
//  flush      in   1         synchronous kill of every in-flight operation
//  out_valid  out  1         result available
//  out_ready  in   1         consumer takes the result this cycle
//  out_res    out  WIDTH     selected product half
//  out_tag    out  TAG_W     tag of the result
//  busy       out  1         at least one stage holds a valid operation
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): every stage valid bit, data register and tag clears to 0.
//    Effects: out_valid=0, out_res=0, out_tag=0, busy=0, in_ready=1. Reset mid-operation
//    discards all in-flight operations with no clock edge needed.
//  - Accept: an operation is accepted when in_valid and in_ready are both 1 at a rising edge,
//    and flush is 0 in that cycle.
//  - Pipeline: LATENCY stages, each holding a valid bit, op, tag and data.
//    Stage 1 registers the extended operands. The product is formed between stage 1 and stage 2.
//    Stages 2..LATENCY delay the product. out_* is driven from stage LATENCY.
//  - Latency: an operation accepted in cycle 0 drives out_valid=1 in cycle LATENCY when no stall occurs.
//  - Throughput: one operation per cycle. Results leave in acceptance order and are never reordered.
//  - Stall: stall = out_valid & ~out_ready.
//    While stall=1, every stage holds its contents, in_ready=0, and out_res/out_tag stay stable.
//    in_ready = ~stall, combinational, with no dependence on in_valid.
//  - Output handshake: a result is consumed on an edge where out_valid=1 and out_ready=1.
//    The next stage's contents (or a bubble) move into the output stage on that same edge.
//  - Flush (synchronous): at the next edge all valid bits clear. busy=0 and out_valid=0 from the
//    following cycle. An input offered in the flush cycle is dropped. Flush overrides stall.
//    Data registers need not clear on flush.
//  - Arithmetic:
//    A is sign-extended for MULH and MULHSU, and zero-extended otherwise.
//    B is sign-extended for MULH only.
//    Both operands are extended to WIDTH+1 bits, and the signed product is 2*WIDTH+2 bits.
//    MUL returns P[WIDTH-1:0]. MULH, MULHSU and MULHU return P[2*WIDTH-1:WIDTH].
//    The low half is identical for all signedness combinations.
//  - busy = OR of all stage valid bits, including the output stage.
//  - Bubbles: invalid stages propagate as bubbles. Their data is don't-care, but out_res and out_tag
//    never change while out_valid=1 and stall=1.
// TESTING
//  1. MULHU and MUL, WIDTH=32: A=B=0xFFFFFFFF -> MULHU 0xFFFFFFFE, MUL 0x00000001,
//     out_valid exactly in cycle LATENCY.
//  2. Signed modes, WIDTH=32:
//     MULH 0x80000000*0x80000000 -> 0x40000000.
//     MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000.
//     MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  3. Streaming: 10 back-to-back ops, tags 0..9, A=i+1, B=3, out_ready=1.
//     Expect results 3,6,..,30 with tags 0..9 in cycles LATENCY..LATENCY+9 and no gaps.
//  4. Backpressure: hold out_ready=0 for 3 cycles while out_valid=1.
//     Expect in_ready=0 and out_res/out_tag stable; after release, all ops are delivered once, in order.
//  5. Flush with 4 ops in flight plus one offered in the same cycle.
//     Expect out_valid=0 and busy=0 next cycle, and none of the 5 results ever appear.
//  6. Pull rst_n low between edges with 3 ops in flight.
//     Expect out_valid=0 and busy=0 immediately.
//     Repeat test 2 with WIDTH=8, LATENCY=2: MULH 0x80*0x80 -> 0x40 in cycle 2.

Source files
------------

// File: rtl/fu_mul_pipe_if.sv
// Handshake bundle for the pipelined multiply unit: issue side, result side, flush and busy.
// The master drives operations and consumes results; the slave is the multiply unit.
interface fu_mul_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_res, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, flush, out_ready,
        output in_ready, out_valid, out_res, out_tag, busy
    );
endinterface

// File: rtl/fu_mul_pipe.sv
// Fully pipelined RISC-V style integer multiplier (MUL/MULH/MULHSU/MULHU) with tag,
// global stall on output backpressure, synchronous flush and busy flag.
module fu_mul_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 7,
    parameter int TAG_W   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    fu_mul_pipe_if.slave  bus
);
    localparam int PW = 2 * WIDTH + 2;

    logic                  stall;
    logic                  advance;
    logic [LATENCY:1]      stage_valid;
    logic [TAG_W-1:0]      stage_tag [1:LATENCY];
    logic [WIDTH-1:0]      stage_res [2:LATENCY];

    // The whole pipe freezes when the output holds a result nobody takes.
    assign stall   = stage_valid[LATENCY] & ~bus.out_ready;
    assign advance = ~stall;

    logic                  a_signed;
    logic                  b_signed;
    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;

    always_comb begin
        a_signed = (bus.in_op == 2'b01) || (bus.in_op == 2'b10);
        b_signed = (bus.in_op == 2'b01);
        a_ext    = {a_signed & bus.in_a[WIDTH-1], bus.in_a};
        b_ext    = {b_signed & bus.in_b[WIDTH-1], bus.in_b};
    end

    logic                  valid1_reg;
    logic [TAG_W-1:0]      tag1_reg;
    logic [1:0]            op1_reg;
    logic signed [WIDTH:0] a1_reg;
    logic signed [WIDTH:0] b1_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_reg <= 1'b0;
            tag1_reg   <= '0;
            op1_reg    <= '0;
            a1_reg     <= '0;
            b1_reg     <= '0;
        end else begin
            if (bus.flush) begin
                valid1_reg <= 1'b0;
            end else if (advance) begin
                valid1_reg <= bus.in_valid;
            end
            if (advance) begin
                tag1_reg <= bus.in_tag;
                op1_reg  <= bus.in_op;
                a1_reg   <= a_ext;
                b1_reg   <= b_ext;
            end
        end
    end

    assign stage_valid[1] = valid1_reg;
    assign stage_tag[1]   = tag1_reg;

    // Both operands are widened to the full product width so the multiply is exact.
    logic signed [PW-1:0]  a_wide;
    logic signed [PW-1:0]  b_wide;
    logic signed [PW-1:0]  prod;
    logic [WIDTH-1:0]      sel_res;
    logic                  unused_prod_hi;

    assign a_wide         = {{(WIDTH+1){a1_reg[WIDTH]}}, a1_reg};
    assign b_wide         = {{(WIDTH+1){b1_reg[WIDTH]}}, b1_reg};
    assign prod           = a_wide * b_wide;
    assign sel_res        = (op1_reg == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    assign unused_prod_hi = ^prod[PW-1:2*WIDTH];

    // Stage 2 captures the selected product half; later stages only delay it.
    for (genvar gi = 2; gi <= LATENCY; gi++) begin : g_stage
        logic             valid_reg;
        logic [TAG_W-1:0] tag_reg;
        logic [WIDTH-1:0] res_reg;
        logic [WIDTH-1:0] res_in;

        if (gi == 2) begin : g_mul
            assign res_in = sel_res;
        end else begin : g_dly
            assign res_in = stage_res[gi-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                tag_reg   <= '0;
                res_reg   <= '0;
            end else begin
                if (bus.flush) begin
                    valid_reg <= 1'b0;
                end else if (advance) begin
                    valid_reg <= stage_valid[gi-1];
                end
                if (advance) begin
                    tag_reg <= stage_tag[gi-1];
                    res_reg <= res_in;
                end
            end
        end

        assign stage_valid[gi] = valid_reg;
        assign stage_tag[gi]   = tag_reg;
        assign stage_res[gi]   = res_reg;
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = stage_valid[LATENCY];
    assign bus.out_res   = stage_res[LATENCY];
    assign bus.out_tag   = stage_tag[LATENCY];
    assign bus.busy      = |stage_valid;
endmodule
